// File: rtl/char_hmove_if.sv
// Control inputs and sprite-position outputs of the horizontal character mover.
// Latency: n/a (signal bundle); backpressure: none, all outputs are level/pulse registered values.
interface char_hmove_if #(
    parameter int POS_W = 11
);
    logic             left;
    logic             right;
    logic             patrol;
    logic             start_game;
    logic             animation;
    logic             respawn;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             facing_right;
    logic             moving;
    logic             at_edge;
    logic             step_pulse;

    modport master (
        output left, right, patrol, start_game, animation, respawn,
        input  xpos, ypos, facing_right, moving, at_edge, step_pulse
    );

    modport slave (
        input  left, right, patrol, start_game, animation, respawn,
        output xpos, ypos, facing_right, moving, at_edge, step_pulse
    );
endinterface

// File: rtl/char_hmove_ctrl.sv
// Horizontal mover for characters: manual hold-to-move or autonomous patrol between playfield limits.
// Latency: request -> ST_MOVE next edge, first xpos change STEP_PERIOD edges later; no backpressure, animation freezes in place.
module char_hmove_ctrl #(
    parameter int POS_W       = 11,
    parameter int STEP_PERIOD = 1_000_000,
    parameter int STEP_SIZE   = 1,
    parameter int XPOS_MIN    = 0,
    parameter int XPOS_MAX    = 640,
    parameter int CHAR_WIDTH  = 64,
    parameter int XPOS_INIT   = 0,
    parameter int YPOS_INIT   = 0
) (
    input  logic         clk,
    input  logic         rst,
    char_hmove_if.slave  bus
);
    localparam int CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int R_INT = XPOS_MAX - CHAR_WIDTH;

    localparam logic [POS_W:0]   C_MIN     = (POS_W+1)'(XPOS_MIN);
    localparam logic [POS_W:0]   C_R       = (POS_W+1)'(R_INT);
    localparam logic [POS_W:0]   C_STEP    = (POS_W+1)'(STEP_SIZE);
    localparam logic [POS_W:0]   C_MIN_LIM = C_MIN + C_STEP;
    localparam logic [CNT_W-1:0] C_TERM    = CNT_W'(STEP_PERIOD - 1);

    typedef enum logic {ST_IDLE, ST_MOVE} state_t;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [POS_W-1:0] r_xpos,   w_xpos_nxt;
    logic [POS_W-1:0] r_ypos;
    logic             r_facing, w_facing_nxt;
    logic             r_step,   w_step_nxt;

    logic             w_en;
    logic             w_at_fwd_lim;
    logic             w_dir;
    logic             w_step_at_lim;
    logic             w_held_fwd;
    logic             w_held_rev;
    logic [POS_W:0]   w_x_ext;
    logic [POS_W:0]   w_x_left;
    logic [POS_W:0]   w_x_right;
    logic [POS_W-1:0] w_x_step;

    assign w_en      = bus.start_game && !bus.animation;
    assign w_x_ext   = {1'b0, r_xpos};
    assign w_x_left  = (w_x_ext < C_MIN_LIM)      ? C_MIN : (w_x_ext - C_STEP);
    assign w_x_right = ((w_x_ext + C_STEP) > C_R) ? C_R   : (w_x_ext + C_STEP);

    // Patrol starting a tick at its forward limit reverses before stepping.
    assign w_at_fwd_lim  = r_facing ? (w_x_ext == C_R) : (w_x_ext == C_MIN);
    assign w_dir         = (bus.patrol && w_at_fwd_lim) ? !r_facing : r_facing;
    assign w_x_step      = POS_W'(w_dir ? w_x_right : w_x_left);
    assign w_step_at_lim = w_dir ? ({1'b0, w_x_step} == C_R) : ({1'b0, w_x_step} == C_MIN);

    assign w_held_fwd = r_facing ? (bus.right && !bus.left) : (bus.left && !bus.right);
    assign w_held_rev = r_facing ? (bus.left && !bus.right) : (bus.right && !bus.left);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_xpos_nxt   = r_xpos;
        w_facing_nxt = r_facing;
        w_step_nxt   = 1'b0;
        if (bus.respawn) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_xpos_nxt   = POS_W'(XPOS_INIT);
            w_facing_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_en && bus.patrol) begin
                        w_state_nxt = ST_MOVE;
                    end else if (w_en && (bus.left ^ bus.right)) begin
                        w_state_nxt  = ST_MOVE;
                        w_facing_nxt = bus.right;
                    end
                end
                ST_MOVE: begin
                    if (!bus.start_game) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (!bus.animation) begin
                        if (r_cnt != C_TERM) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end else begin
                            w_cnt_nxt  = '0;
                            w_xpos_nxt = w_x_step;
                            w_step_nxt = 1'b1;
                            if (bus.patrol) begin
                                w_facing_nxt = w_step_at_lim ? !w_dir : w_dir;
                            end else if (w_held_rev) begin
                                w_facing_nxt = !r_facing;
                            end else if (!w_held_fwd) begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_xpos   <= POS_W'(XPOS_INIT);
            r_ypos   <= POS_W'(YPOS_INIT);
            r_facing <= 1'b1;
            r_step   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_xpos   <= w_xpos_nxt;
            r_facing <= w_facing_nxt;
            r_step   <= w_step_nxt;
        end
    end

    assign bus.xpos         = r_xpos;
    assign bus.ypos         = r_ypos;
    assign bus.facing_right = r_facing;
    assign bus.moving       = (r_state == ST_MOVE);
    assign bus.at_edge      = (w_x_ext == C_MIN) || (w_x_ext == C_R);
    assign bus.step_pulse   = r_step;
endmodule

// File: tb/tb_char_hmove_ctrl.sv
// Directed bench for char_hmove_ctrl: three instances (xpos init 100, 1, 573) share clk/rst.
// Expected step events are queued when stimulus is driven and popped whenever a step_pulse is seen.
module tb_char_hmove_ctrl;
    localparam int POS_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    char_hmove_if #(.POS_W(POS_W)) ifa ();
    char_hmove_if #(.POS_W(POS_W)) ifb ();
    char_hmove_if #(.POS_W(POS_W)) ifc ();

    char_hmove_ctrl #(.POS_W(POS_W), .STEP_PERIOD(4), .STEP_SIZE(2), .XPOS_MIN(0), .XPOS_MAX(640),
                      .CHAR_WIDTH(64), .XPOS_INIT(100), .YPOS_INIT(200))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    char_hmove_ctrl #(.POS_W(POS_W), .STEP_PERIOD(4), .STEP_SIZE(2), .XPOS_MIN(0), .XPOS_MAX(640),
                      .CHAR_WIDTH(64), .XPOS_INIT(1), .YPOS_INIT(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    char_hmove_ctrl #(.POS_W(POS_W), .STEP_PERIOD(4), .STEP_SIZE(2), .XPOS_MIN(0), .XPOS_MAX(640),
                      .CHAR_WIDTH(64), .XPOS_INIT(573), .YPOS_INIT(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int id;
        int x;
        int f;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   e0       = 0;

    task automatic chk(input string tag, input int obs, input int want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic push(input int id, input int x, input int f, input int c);
        exp_t e;
        e.id  = id;
        e.x   = x;
        e.f   = f;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic mon();
        logic sp [3];
        int   xv [3];
        int   fv [3];
        exp_t e;
        sp[0] = ifa.step_pulse; xv[0] = int'(ifa.xpos); fv[0] = int'(ifa.facing_right);
        sp[1] = ifb.step_pulse; xv[1] = int'(ifb.xpos); fv[1] = int'(ifb.facing_right);
        sp[2] = ifc.step_pulse; xv[2] = int'(ifc.xpos); fv[2] = int'(ifc.facing_right);
        for (int d = 0; d < 3; d++) begin
            if (sp[d]) begin
                n_assert++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_step dut=%0d cycle=%0d observed=pulse expected=none", d, cyc);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_dut", d, e.id);
                    chk("sb_xpos", xv[d], e.x);
                    chk("sb_facing", fv[d], e.f);
                    chk("sb_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        mon();
    endtask

    initial begin
        ifa.left = 0; ifa.right = 0; ifa.patrol = 0; ifa.start_game = 0; ifa.animation = 0; ifa.respawn = 0;
        ifb.left = 0; ifb.right = 0; ifb.patrol = 0; ifb.start_game = 0; ifb.animation = 0; ifb.respawn = 0;
        ifc.left = 0; ifc.right = 0; ifc.patrol = 0; ifc.start_game = 0; ifc.animation = 0; ifc.respawn = 0;
        rst = 1;
        repeat (2) step();

        // Reset state
        chk("rst_xpos_a", int'(ifa.xpos), 100);
        chk("rst_ypos_a", int'(ifa.ypos), 200);
        chk("rst_facing_a", int'(ifa.facing_right), 1);
        chk("rst_moving_a", int'(ifa.moving), 0);
        chk("rst_pulse_a", int'(ifa.step_pulse), 0);
        chk("rst_edge_a", int'(ifa.at_edge), 0);
        chk("rst_xpos_b", int'(ifb.xpos), 1);
        chk("rst_xpos_c", int'(ifc.xpos), 573);
        chk("rst_ypos_c", int'(ifc.ypos), 0);

        rst = 0;
        ifa.start_game = 1; ifb.start_game = 1; ifc.start_game = 1;
        repeat (2) step();

        // Single-cycle right request: one step, then idle
        e0 = cyc; ifa.right = 1;
        push(0, 102, 1, e0 + 5);
        step();
        chk("t1_moving", int'(ifa.moving), 1);
        ifa.right = 0;
        repeat (4) step();
        chk("t1_xpos", int'(ifa.xpos), 102);
        chk("t1_idle", int'(ifa.moving), 0);
        repeat (3) step();

        // Held right, then a 10-cycle freeze mid-interval
        e0 = cyc; ifa.right = 1;
        push(0, 104, 1, e0 + 5);
        push(0, 106, 1, e0 + 9);
        push(0, 108, 1, e0 + 13);
        push(0, 110, 1, e0 + 27);
        repeat (15) step();
        ifa.animation = 1;
        repeat (10) begin
            step();
            chk("t5_frozen_moving", int'(ifa.moving), 1);
            chk("t5_frozen_xpos", int'(ifa.xpos), 108);
        end
        ifa.animation = 0;
        step();
        ifa.right = 0;
        step();
        chk("t5_xpos", int'(ifa.xpos), 110);
        chk("t5_idle", int'(ifa.moving), 0);
        repeat (3) step();

        // Walk to 300, then respawn on the tick that would leave 300
        e0 = cyc; ifa.right = 1;
        for (int k = 1; k <= 95; k++) push(0, 110 + 2 * k, 1, e0 + 1 + 4 * k);
        for (int i = 1; i <= 385; i++) begin
            step();
            if (i == 384) ifa.respawn = 1;
        end
        ifa.respawn = 0;
        chk("t6_xpos", int'(ifa.xpos), 100);
        chk("t6_pulse", int'(ifa.step_pulse), 0);
        chk("t6_idle", int'(ifa.moving), 0);
        chk("t6_facing", int'(ifa.facing_right), 1);
        ifa.right = 0;
        step();
        chk("t6_still_idle", int'(ifa.moving), 0);
        ifa.left = 1; ifa.right = 1;
        repeat (8) begin
            step();
            chk("t6_both_moving", int'(ifa.moving), 0);
            chk("t6_both_xpos", int'(ifa.xpos), 100);
        end
        ifa.left = 0; ifa.right = 0;
        step();

        // start_game drop mid-interval: idle, xpos kept
        ifa.right = 1;
        repeat (2) step();
        ifa.start_game = 0;
        step();
        chk("sg_idle", int'(ifa.moving), 0);
        chk("sg_xpos", int'(ifa.xpos), 100);
        repeat (6) step();
        ifa.right = 0;

        // Left saturation at XPOS_MIN with step_pulse still firing
        e0 = cyc; ifb.left = 1;
        push(1, 0, 0, e0 + 5);
        push(1, 0, 0, e0 + 9);
        push(1, 0, 0, e0 + 13);
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 12) ifb.left = 0;
        end
        chk("t3_xpos", int'(ifb.xpos), 0);
        chk("t3_at_edge", int'(ifb.at_edge), 1);
        chk("t3_idle", int'(ifb.moving), 0);
        repeat (3) step();

        // Patrol bounce at the right limit, then patrol released mid-interval
        e0 = cyc; ifc.patrol = 1;
        push(2, 575, 1, e0 + 5);
        push(2, 576, 0, e0 + 9);
        push(2, 574, 0, e0 + 13);
        push(2, 572, 0, e0 + 17);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 9) chk("t4_at_edge", int'(ifc.at_edge), 1);
            if (i == 16) ifc.patrol = 0;
        end
        chk("t4_idle", int'(ifc.moving), 0);
        chk("t4_facing", int'(ifc.facing_right), 0);
        repeat (4) step();

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
